// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with frame-boundary run/stop gating
module video_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_BLANK  = 280,
    parameter int V_ACTIVE = 1080,
    parameter int V_BLANK  = 45,
    parameter int CW       = 12
) (
    input  logic          i_pclk,
    input  logic          i_rst_n,
    input  logic          i_en,
    output logic          o_sync_h,
    output logic          o_sync_v,
    output logic [CW-1:0] o_hcount,
    output logic [CW-1:0] o_vcount,
    output logic          o_frame_start,
    output logic          o_busy
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_W = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_W = CW'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic          sync_h_q, sync_h_d;
    logic          sync_v_q, sync_v_d;
    logic          frame_start_q, frame_start_d;
    logic          busy_q, busy_d;
    logic          end_of_line;
    logic          end_of_frame;

    always_comb begin
        state_d       = state_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        end_of_line   = (hcount_q == H_LAST);
        end_of_frame  = end_of_line && (vcount_q == V_LAST);

        case (state_q)
            IDLE: begin
                hcount_d = '0;
                vcount_d = '0;
                if (i_en) begin
                    state_d = RUN;
                end
            end
            RUN, DRAIN: begin
                if (end_of_line) begin
                    hcount_d = '0;
                    vcount_d = end_of_frame ? '0 : vcount_q + 1'b1;
                end else begin
                    hcount_d = hcount_q + 1'b1;
                end
                // Only the enable seen on the frame's last pixel can stop the raster.
                if (end_of_frame && !i_en) begin
                    state_d = IDLE;
                end else begin
                    state_d = i_en ? RUN : DRAIN;
                end
            end
            default: begin
                state_d  = IDLE;
                hcount_d = '0;
                vcount_d = '0;
            end
        endcase

        // Decode from next-state values so every registered output lines up with the counters.
        busy_d        = (state_d != IDLE);
        sync_v_d      = busy_d && (vcount_d < V_ACT_W);
        sync_h_d      = sync_v_d && (hcount_d < H_ACT_W);
        frame_start_d = busy_d && (hcount_d == '0) && (vcount_d == '0);
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            hcount_q      <= '0;
            vcount_q      <= '0;
            sync_h_q      <= 1'b0;
            sync_v_q      <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            sync_h_q      <= sync_h_d;
            sync_v_q      <= sync_v_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign o_sync_h      = sync_h_q;
    assign o_sync_v      = sync_v_q;
    assign o_hcount      = hcount_q;
    assign o_vcount      = vcount_q;
    assign o_frame_start = frame_start_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen on a small raster
module tb_video_timing_gen;

    localparam int HA = 8;
    localparam int HB = 4;
    localparam int VA = 4;
    localparam int VB = 2;
    localparam int CW = 4;
    localparam int HT = HA + HB;
    localparam int VT = VA + VB;
    localparam int FL = HT * VT;

    logic          i_pclk;
    logic          i_rst_n;
    logic          i_en;
    logic          o_sync_h;
    logic          o_sync_v;
    logic [CW-1:0] o_hcount;
    logic [CW-1:0] o_vcount;
    logic          o_frame_start;
    logic          o_busy;

    int total;
    int bad;

    // Reference: a frame is a flat sequence of FL pixels indexed by pos.
    bit running;
    int pos;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .CW(CW)
    ) dut (
        .i_pclk       (i_pclk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_en),
        .o_sync_h     (o_sync_h),
        .o_sync_v     (o_sync_v),
        .o_hcount     (o_hcount),
        .o_vcount     (o_vcount),
        .o_frame_start(o_frame_start),
        .o_busy       (o_busy)
    );

    initial i_pclk = 1'b0;
    always #5 i_pclk = ~i_pclk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d pos=%0d", tag, obs, exp, pos);
        end
    endtask

    task automatic check_all();
        int eh;
        int ev;
        eh = running ? pos % HT : 0;
        ev = running ? pos / HT : 0;
        chk("hcount", int'(o_hcount), eh);
        chk("vcount", int'(o_vcount), ev);
        chk("busy", int'(o_busy), int'(running));
        chk("sync_v", int'(o_sync_v), int'(running && ev < VA));
        chk("sync_h", int'(o_sync_h), int'(running && ev < VA && eh < HA));
        chk("frame_start", int'(o_frame_start), int'(running && pos == 0));
    endtask

    task automatic model_edge(input bit en);
        if (!running) begin
            if (en) begin
                running = 1'b1;
                pos = 0;
            end
        end else if (pos == FL - 1) begin
            pos = 0;
            running = en;
        end else begin
            pos++;
        end
    endtask

    task automatic step(input bit en);
        i_en = en;
        @(posedge i_pclk);
        model_edge(en);
        #1;
        check_all();
    endtask

    initial begin
        int sv_cnt;
        int sh_cnt;
        int runs;
        int fs_cnt;
        bit prev_h;
        total = 0;
        bad = 0;
        running = 1'b0;
        pos = 0;
        i_rst_n = 1'b0;
        i_en = 1'b1;

        // Reset held with enable high
        repeat (3) @(posedge i_pclk);
        #1;
        check_all();
        i_rst_n = 1'b1;
        step(1'b1);
        chk("first_frame_start", int'(o_frame_start), 1);

        // One full frame plus the first pixel of the next
        sv_cnt = 0; sh_cnt = 0; runs = 0; fs_cnt = 0; prev_h = 1'b0;
        for (int c = 0; c < FL; c++) begin
            if (c > 0) step(1'b1);
            sv_cnt += int'(o_sync_v);
            sh_cnt += int'(o_sync_h);
            fs_cnt += int'(o_frame_start);
            if (o_sync_h && !prev_h) runs++;
            prev_h = o_sync_h;
        end
        chk("frame_sync_v_cycles", sv_cnt, VA * HT);
        chk("frame_sync_h_cycles", sh_cnt, VA * HA);
        chk("frame_sync_h_runs", runs, VA);
        chk("frame_start_count", fs_cnt, 1);
        step(1'b1);
        chk("frame_start_at_72", int'(o_frame_start), 1);

        // Drop enable at (3,1): frame completes, then idle
        for (int c = 0; c < 3 * FL && !(running && pos == 1 * HT + 3); c++) step(1'b1);
        chk("reached_3_1", pos, 1 * HT + 3);
        for (int c = 0; c < FL + 4; c++) step(1'b0);
        chk("idle_after_drain", int'(o_busy), 0);

        // Drop at (3,1), rise at (5,4): seamless continuation
        step(1'b1);
        for (int c = 0; c < 2 * FL; c++)
            step(!(pos >= 1 * HT + 3 && pos < 4 * HT + 5));
        chk("seamless_busy", int'(o_busy), 1);

        // Asynchronous reset mid-cycle at (6,2)
        for (int c = 0; c < 2 * FL && !(running && pos == 2 * HT + 6); c++) step(1'b1);
        chk("reached_6_2", pos, 2 * HT + 6);
        #2;
        i_rst_n = 1'b0;
        #1;
        running = 1'b0;
        pos = 0;
        check_all();
        #2;
        i_rst_n = 1'b1;
        step(1'b0);
        step(1'b1);
        chk("restart_frame_start", int'(o_frame_start), 1);

        // Randomised enable: mixture of sticky levels and per-cycle noise
        for (int blk = 0; blk < 60; blk++) begin
            int len;
            int mode;
            bit lvl;
            len = $urandom_range(5, 120);
            mode = $urandom_range(0, 2);
            lvl = 1'($urandom_range(0, 1));
            for (int c = 0; c < len; c++) begin
                if (mode == 2) step(1'($urandom_range(0, 1)));
                else step(lvl);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
